// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encodings, default sizes
// and a two's-complement conditional-negate helper.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;
  // Widest operand the negate helper supports; callers zero-extend and truncate.
  localparam int DIV_MAX_W = 64;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Negating modulo 2^64 and truncating equals negating modulo 2^WIDTH.
  function automatic logic [DIV_MAX_W-1:0] cond_neg(input logic [DIV_MAX_W-1:0] x,
                                                    input logic                 neg);
    return neg ? (~x + DIV_MAX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left, trial-subtract the
// divisor, keep the difference and set the quotient bit when it does not borrow.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dvs_ext;
  logic           ge;

  always_comb begin
    shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    dvs_ext = {1'b0, divisor};
    ge      = (shifted >= dvs_ext);
    rem_nxt = ge ? (shifted - dvs_ext) : shifted;
    quo_nxt = {quo[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed divider: one restoring step per clock, WIDTH+1 cycles from start to
// the one-cycle ready pulse (1 cycle for divide-by-zero/overflow); a new start always wins.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic             special;

  // abs(-2^(WIDTH-1)) wraps to itself, which reads correctly as unsigned 2^(WIDTH-1).
  assign abs_a   = WIDTH'(cond_neg(DIV_MAX_W'(data_operandA), data_operandA[WIDTH-1]));
  assign abs_b   = WIDTH'(cond_neg(DIV_MAX_W'(data_operandB), data_operandB[WIDTH-1]));
  assign special = (data_operandB == '0) ||
                   ((data_operandA == MIN_NEG) && (data_operandB == '1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // Final step's output is sign-corrected and published on the same edge.
  assign q_fin = WIDTH'(cond_neg(DIV_MAX_W'(quo_nxt), sign_q));
  assign r_fin = WIDTH'(cond_neg(DIV_MAX_W'(rem_nxt[WIDTH-1:0]), sign_r));

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvs_q          <= '0;
      sign_q         <= 1'b0;
      sign_r         <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        cnt            <= '0;
        rem_q          <= '0;
        quo_q          <= abs_a;
        dvs_q          <= abs_b;
        sign_q         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        sign_r         <= data_operandA[WIDTH-1];
        data_exception <= special;
        if (special) begin
          data_result    <= '0;
          data_remainder <= '0;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state          <= DONE;
        end else begin
          busy  <= 1'b1;
          state <= BUSY;
        end
      end else begin
        case (state)
          BUSY: begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              data_result    <= q_fin;
              data_remainder <= r_fin;
              data_resultRDY <= 1'b1;
              busy           <= 1'b0;
              state          <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against a plain-arithmetic signed division model.
module tb_seq_divider;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
  logic [W-1:0] data_remainder;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int tests = 0;
  int fails = 0;

  seq_divider dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Reference: C-style signed division (truncate toward zero, remainder follows dividend).
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic e, output int lat);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0 || (sa == -64'sd2147483648 && sb == -64'sd1)) begin
      q = '0; r = '0; e = 1'b1; lat = 1;
    end else begin
      q = W'(sa / sb); r = W'(sa % sb); e = 1'b0; lat = W + 1;
    end
  endtask

  // Drives one start pulse in a cycle of its own and waits for ready; cycle 1 is the start edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic e, output int busy_low);
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    lat = -1; busy_low = 0; q = '0; r = '0; e = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (data_resultRDY) begin
        lat = c; q = data_result; r = data_remainder; e = data_exception;
        break;
      end
      if (!busy) busy_low++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    tests++; if (data_result !== '0) begin fails++; $display("FAIL reset_result got %h exp 0", data_result); end
    tests++; if (data_remainder !== '0) begin fails++; $display("FAIL reset_rem got %h exp 0", data_remainder); end
    tests++; if (data_exception !== 1'b0) begin fails++; $display("FAIL reset_exc got %b exp 0", data_exception); end
    tests++; if (data_resultRDY !== 1'b0) begin fails++; $display("FAIL reset_rdy got %b exp 0", data_resultRDY); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bl, elat; logic [W-1:0] q, r, eq, er; logic e, ee;
    model(32'd100, 32'd7, eq, er, ee, elat);
    run_op(32'd100, 32'd7, lat, q, r, e, bl);
    tests++; if (lat != elat) begin fails++; $display("FAIL basic_latency got %0d exp %0d", lat, elat); end
    tests++; if (q !== eq) begin fails++; $display("FAIL basic_quotient got %0d exp %0d", q, eq); end
    tests++; if (r !== er) begin fails++; $display("FAIL basic_remainder got %0d exp %0d", r, er); end
    tests++; if (e !== ee) begin fails++; $display("FAIL basic_exception got %b exp %b", e, ee); end
    tests++; if (bl != 0) begin fails++; $display("FAIL basic_busy got %0d low cycles exp 0", bl); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_done got %b exp 0", busy); end
    @(negedge clock);
    tests++; if (data_resultRDY !== 1'b0) begin fails++; $display("FAIL basic_rdy_pulse got %b exp 0", data_resultRDY); end
    tests++; if (data_result !== eq) begin fails++; $display("FAIL basic_hold got %h exp %h", data_result, eq); end
  endtask

  task automatic test_signs();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    int lat, bl, elat; logic [W-1:0] q, r, eq, er; logic e, ee;
    ta[0] = -32'sd100; tb[0] = 32'd7;
    ta[1] = 32'd100;   tb[1] = -32'sd7;
    ta[2] = -32'sd100; tb[2] = -32'sd7;
    ta[3] = 32'h8000_0000; tb[3] = 32'd3;
    for (int i = 0; i < 4; i++) begin
      model(ta[i], tb[i], eq, er, ee, elat);
      run_op(ta[i], tb[i], lat, q, r, e, bl);
      tests++;
      if (lat != elat || q !== eq || r !== er || e !== ee) begin
        fails++;
        $display("FAIL signs[%0d] got lat=%0d q=%h r=%h e=%b exp lat=%0d q=%h r=%h e=%b",
                 i, lat, q, r, e, elat, eq, er, ee);
      end
    end
  endtask

  task automatic test_special();
    int lat, bl; logic [W-1:0] q, r; logic e;
    run_op(32'd5, 32'd0, lat, q, r, e, bl);
    tests++; if (lat != 1 || e !== 1'b1 || q !== '0 || r !== '0) begin
      fails++; $display("FAIL div_zero got lat=%0d e=%b q=%h r=%h exp lat=1 e=1 q=0 r=0", lat, e, q, r);
    end
    run_op(32'd9, 32'd3, lat, q, r, e, bl);
    tests++; if (lat != W + 1 || e !== 1'b0 || q !== 32'd3 || r !== '0) begin
      fails++; $display("FAIL after_zero got lat=%0d e=%b q=%h r=%h exp lat=33 e=0 q=3 r=0", lat, e, q, r);
    end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, lat, q, r, e, bl);
    tests++; if (lat != 1 || e !== 1'b1 || q !== '0 || r !== '0) begin
      fails++; $display("FAIL overflow got lat=%0d e=%b q=%h r=%h exp lat=1 e=1 q=0 r=0", lat, e, q, r);
    end
  endtask

  task automatic test_random();
    int lat, bl, elat; logic [W-1:0] a, b, q, r, eq, er; logic e, ee;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = W'($urandom_range(0, 40)) - W'(20);
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = -($urandom >> $urandom_range(8, 31));
      endcase
      model(a, b, eq, er, ee, elat);
      run_op(a, b, lat, q, r, e, bl);
      tests++;
      if (lat != elat || q !== eq || r !== er || e !== ee || (elat > 1 && bl != 0)) begin
        fails++;
        $display("FAIL random[%0d] a=%h b=%h got lat=%0d q=%h r=%h e=%b busylow=%0d exp lat=%0d q=%h r=%h e=%b",
                 i, a, b, lat, q, r, e, bl, elat, eq, er, ee);
      end
    end
  endtask

  task automatic test_restart();
    int rdy_at = -1; logic [W-1:0] q = '0, r = '0;
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (data_resultRDY && rdy_at < 0) begin rdy_at = c; q = data_result; r = data_remainder; end
      ctrl_DIV = (c == 10);
      if (c == 10) begin data_operandA = 32'd50; data_operandB = 32'd5; end
    end
    tests++; if (rdy_at != 43) begin fails++; $display("FAIL restart_latency got %0d exp 43", rdy_at); end
    tests++; if (q !== 32'd10 || r !== '0) begin fails++; $display("FAIL restart_value got q=%0d r=%0d exp q=10 r=0", q, r); end
  endtask

  task automatic test_reset_midop();
    int rdy_cnt = 0, lat, bl; logic [W-1:0] q, r; logic e;
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clock);
      ctrl_DIV = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tests++; if (data_result !== '0 || data_remainder !== '0 || data_exception !== 1'b0 ||
                 data_resultRDY !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL midop_reset got q=%h r=%h e=%b rdy=%b busy=%b exp all 0",
                        data_result, data_remainder, data_exception, data_resultRDY, busy);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_cnt++;
    end
    tests++; if (rdy_cnt != 0) begin fails++; $display("FAIL midop_no_rdy got %0d pulses exp 0", rdy_cnt); end
    run_op(32'd7, 32'd7, lat, q, r, e, bl);
    tests++; if (lat != W + 1 || q !== 32'd1 || r !== '0 || e !== 1'b0) begin
      fails++; $display("FAIL midop_fresh got lat=%0d q=%h r=%h e=%b exp lat=33 q=1 r=0 e=0", lat, q, r, e);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bl, lat2 = -1; logic [W-1:0] q, r, eq, er; logic e, ee;
    int elat;
    run_op(-32'sd1000, 32'd33, lat, q, r, e, bl);
    model(-32'sd1000, 32'd33, eq, er, ee, elat);
    tests++; if (lat != elat || q !== eq || r !== er) begin
      fails++; $display("FAIL b2b_first got lat=%0d q=%h r=%h exp lat=%0d q=%h r=%h", lat, q, r, elat, eq, er);
    end
    // Start the next operation in the DONE cycle.
    ctrl_DIV = 1'b1; data_operandA = 32'd12345; data_operandB = -32'sd100;
    model(32'd12345, -32'sd100, eq, er, ee, elat);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    tests++; if (data_resultRDY !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL b2b_start got rdy=%b busy=%b exp rdy=0 busy=1", data_resultRDY, busy);
    end
    for (int c = 1; c <= 100; c++) begin
      if (data_resultRDY) begin lat2 = c; q = data_result; r = data_remainder; e = data_exception; break; end
      @(negedge clock);
    end
    tests++; if (lat2 != elat || q !== eq || r !== er || e !== ee) begin
      fails++; $display("FAIL b2b_second got lat=%0d q=%h r=%h e=%b exp lat=%0d q=%h r=%h e=%b",
                        lat2, q, r, e, elat, eq, er, ee);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_special();
    test_random();
    test_restart();
    test_reset_midop();
    test_back_to_back();
    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
